// File: rtl/averager_pkg.sv
// Shared types and width helpers for the coherent averager.
package averager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_COLLECT   = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_OUTPUT    = 3'd4
    } state_t;

    // Accumulator wide enough that 2^max_log2_avg full-scale samples cannot overflow.
    function automatic int unsigned acc_width(input int unsigned sample_width,
                                              input int unsigned max_log2_avg);
        return sample_width + max_log2_avg;
    endfunction

endpackage

// File: rtl/acc_ram.sv
// Simple dual-port accumulator memory: one write port, one registered read port.
module acc_ram #(
    parameter int unsigned DATA_WIDTH = 26,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read data holds while rd_en is low, which the output prefetch relies on.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/coherent_averager.sv
// Triggered coherent averager: sums 2^log2_avg records of N samples and
// streams the floor-scaled average out over AXI-Stream.
module coherent_averager
    import averager_pkg::*;
#(
    parameter  int unsigned SAMPLE_WIDTH        = 16,
    parameter  int unsigned SAMPLES_PER_TRIGGER = 1024,
    parameter  int unsigned MAX_LOG2_AVG        = 10,
    localparam int unsigned L2_W                = $clog2(MAX_LOG2_AVG + 1),
    localparam int unsigned STRB_W              = (SAMPLE_WIDTH + 7) / 8
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic                    trig,
    input  logic [L2_W-1:0]         log2_avg,
    input  logic                    s00_axis_tvalid,
    input  logic [SAMPLE_WIDTH-1:0] s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic                    m00_axis_tready,
    output logic                    m00_axis_tvalid,
    output logic [SAMPLE_WIDTH-1:0] m00_axis_tdata,
    output logic                    m00_axis_tlast,
    output logic [STRB_W-1:0]       m00_axis_tstrb,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    missed_trig
);

    localparam int unsigned ACC_WIDTH = acc_width(SAMPLE_WIDTH, MAX_LOG2_AVG);
    localparam int unsigned N         = SAMPLES_PER_TRIGGER;
    localparam int unsigned IDX_W     = $clog2(N);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam int unsigned PASS_W    = MAX_LOG2_AVG + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]  RECORD_LEN = CNT_W'(N);
    localparam logic [L2_W-1:0]   L2_MAX     = L2_W'(MAX_LOG2_AVG);

    wire clk = s00_axis_aclk;
    wire rst = s00_axis_areset;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] pass_nxt;
    logic [PASS_W-1:0] pass_inc;
    logic [PASS_W-1:0] avg_target;
    logic [L2_W-1:0]   log2_q;

    logic start_run;
    logic restart;
    logic collect_beat;
    logic drain;
    logic out_active;
    logic last_beat;
    logic final_pass;
    logic out_done;

    // Accumulate pipeline (write stage, one cycle behind the read)
    logic                           wr_en_q;
    logic [IDX_W-1:0]               wr_addr_q;
    logic                           wr_first_q;
    logic signed [SAMPLE_WIDTH-1:0] wr_sample_q;
    logic [ACC_WIDTH-1:0]           sample_ext;
    logic [ACC_WIDTH-1:0]           wr_data;

    logic                 rd_en;
    logic [IDX_W-1:0]     rd_addr;
    logic [ACC_WIDTH-1:0] rd_data;

    // Output prefetch pipeline
    logic [CNT_W-1:0] rd_cnt;
    logic [IDX_W-1:0] out_cnt;
    logic             s1_valid;
    logic             load_out;
    logic             issue;

    assign pass_inc   = PASS_W'(pass_cnt + PASS_W'(1));
    assign avg_target = PASS_W'(1) << log2_q;
    assign final_pass = (pass_inc == avg_target);
    assign last_beat  = collect_beat && (idx == LAST_IDX);
    assign out_done   = out_active && m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (trig) state_nxt = ST_COLLECT;
            ST_WAIT_TRIG: if (trig) state_nxt = ST_COLLECT;
            ST_COLLECT:   if (last_beat) state_nxt = final_pass ? ST_DRAIN : ST_WAIT_TRIG;
            ST_DRAIN:     state_nxt = ST_OUTPUT;
            ST_OUTPUT:    if (out_done) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State decode
    always_comb begin
        start_run    = 1'b0;
        restart      = 1'b0;
        collect_beat = 1'b0;
        drain        = 1'b0;
        out_active   = 1'b0;
        case (state)
            ST_IDLE:      start_run    = trig;
            ST_WAIT_TRIG: restart      = trig;
            ST_COLLECT:   collect_beat = s00_axis_tvalid && s00_axis_tready;
            ST_DRAIN:     drain        = 1'b1;
            ST_OUTPUT:    out_active   = 1'b1;
            default:      ;
        endcase
    end

    always_comb begin
        pass_nxt = pass_cnt;
        if (start_run || out_done) begin
            pass_nxt = '0;
        end else if (last_beat) begin
            pass_nxt = pass_inc;
        end
    end

    // Run control, status flags and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            pass_cnt        <= '0;
            log2_q          <= '0;
            frame_err       <= 1'b0;
            missed_trig     <= 1'b0;
            busy            <= 1'b0;
            s00_axis_tready <= 1'b1;
        end else begin
            pass_cnt        <= pass_nxt;
            busy            <= (state_nxt != ST_IDLE) || (pass_nxt != '0);
            s00_axis_tready <= (state_nxt == ST_IDLE) || (state_nxt == ST_WAIT_TRIG) ||
                               (state_nxt == ST_COLLECT);
            if (start_run) begin
                log2_q <= (log2_avg > L2_MAX) ? L2_MAX : log2_avg;
            end
            if (start_run || restart) begin
                idx <= '0;
            end else if (collect_beat) begin
                idx <= (idx == LAST_IDX) ? '0 : IDX_W'(idx + IDX_W'(1));
            end
            if (collect_beat && (s00_axis_tlast != (idx == LAST_IDX))) begin
                frame_err <= 1'b1;
            end
            if (trig && (state != ST_IDLE) && (state != ST_WAIT_TRIG)) begin
                missed_trig <= 1'b1;
            end
        end
    end

    // Read on the beat, write the updated sum one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= collect_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (collect_beat) begin
            wr_addr_q   <= idx;
            wr_first_q  <= (pass_cnt == '0);
            wr_sample_q <= s00_axis_tdata;
        end
    end

    assign sample_ext = ACC_WIDTH'(wr_sample_q);
    assign wr_data    = wr_first_q ? sample_ext : ACC_WIDTH'(rd_data + sample_ext);

    assign load_out = out_active && (!m00_axis_tvalid || m00_axis_tready);
    assign issue    = out_active && (rd_cnt != RECORD_LEN) && (!s1_valid || load_out);
    assign rd_en    = collect_beat || issue;
    assign rd_addr  = out_active ? rd_cnt[IDX_W-1:0] : idx;

    acc_ram #(
        .DATA_WIDTH (ACC_WIDTH),
        .DEPTH      (N),
        .ADDR_WIDTH (IDX_W)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Two-stage output: RAM read register (s1) feeding the AXIS output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt          <= '0;
            out_cnt         <= '0;
            s1_valid        <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (drain) begin
            rd_cnt   <= '0;
            out_cnt  <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (issue) begin
                rd_cnt   <= CNT_W'(rd_cnt + CNT_W'(1));
                s1_valid <= 1'b1;
            end else if (load_out) begin
                s1_valid <= 1'b0;
            end
            if (load_out) begin
                m00_axis_tvalid <= s1_valid;
                m00_axis_tlast  <= s1_valid && (out_cnt == LAST_IDX);
                if (s1_valid) begin
                    m00_axis_tdata <= SAMPLE_WIDTH'($signed(rd_data) >>> log2_q);
                    out_cnt        <= IDX_W'(out_cnt + IDX_W'(1));
                end
            end
        end
    end

    assign m00_axis_tstrb = '1;

endmodule
